// File: rtl/cinema_pkg.sv
// Shared encodings and default calendar geometry for the cinema time generator.
package cinema_pkg;

    // Run-mode encoding presented on mode_i.
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FAST   = 2'b01,
        MODE_PAUSE  = 2'b10,
        MODE_STEP   = 2'b11
    } mode_e;

    localparam int unsigned DAYS_DEF   = 7;
    localparam int unsigned SLOTS_DEF  = 10;
    localparam int unsigned DAY_W_DEF  = 5;
    localparam int unsigned SLOT_W_DEF = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler with a runtime terminal count; emits a one-cycle adv
// on the cycle the count reaches tc, then restarts from zero.
module tick_prescaler #(
    parameter int unsigned MAX_TICKS = 2,
    localparam int unsigned CNT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] tc,
    input  logic             run,
    input  logic             clr,
    output logic             adv
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_tc;

    // >= guards against a count left above a freshly lowered tc.
    assign w_at_tc = (r_cnt >= tc);
    assign adv     = run & ~clr & w_at_tc;

    // Count while running; any clear, idle or terminal cycle returns to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || !run || w_at_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cinema_time_gen.sv
// Simulated (day, slot) calendar with run modes, time load and event pulses.
// Constraints: 1 <= FAST_TICKS <= NORMAL_TICKS, 2**DAY_W > DAYS, 2**SLOT_W >= SLOTS.
module cinema_time_gen
    import cinema_pkg::*;
#(
    parameter int unsigned NORMAL_TICKS = 1_000_000_000,
    parameter int unsigned FAST_TICKS   = 50_000_000,
    parameter int unsigned DAYS         = DAYS_DEF,
    parameter int unsigned SLOTS        = SLOTS_DEF,
    parameter int unsigned DAY_W        = DAY_W_DEF,
    parameter int unsigned SLOT_W       = SLOT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode_i,
    input  logic                    step_i,
    input  logic                    load_i,
    input  logic [DAY_W-1:0]        load_day_i,
    input  logic [SLOT_W-1:0]       load_slot_i,
    output logic [DAY_W-1:0]        day_o,
    output logic [SLOT_W-1:0]       slot_o,
    output logic [DAY_W+SLOT_W-1:0] r_time_o,
    output logic                    slot_tick_o,
    output logic                    day_tick_o,
    output logic                    week_wrap_o,
    output logic                    load_err_o
);

    localparam int unsigned CNT_W = (NORMAL_TICKS > 1) ? $clog2(NORMAL_TICKS) : 1;

    localparam logic [CNT_W-1:0]  TC_NORMAL = CNT_W'(NORMAL_TICKS - 1);
    localparam logic [CNT_W-1:0]  TC_FAST   = CNT_W'(FAST_TICKS - 1);
    localparam logic [DAY_W-1:0]  DAY_MAX   = DAY_W'(DAYS);
    localparam logic [DAY_W-1:0]  DAY_FIRST = DAY_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(SLOTS - 1);

    mode_e               r_mode;
    logic [DAY_W-1:0]    r_day;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_slot_tick;
    logic                r_day_tick;
    logic                r_week_wrap;
    logic                r_load_err;

    mode_e               w_mode;
    logic                w_mode_chg;
    logic                w_run;
    logic                w_load_ok;
    logic                w_clr;
    logic [CNT_W-1:0]    w_tc;
    logic                w_pre_adv;
    logic                w_step_adv;
    logic                w_adv;
    logic [DAY_W-1:0]    w_day_nxt;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic                w_slot_tick_nxt;
    logic                w_day_tick_nxt;
    logic                w_week_wrap_nxt;
    logic                w_load_err_nxt;

    assign w_mode     = mode_e'(mode_i);
    assign w_mode_chg = (w_mode != r_mode);
    assign w_run      = !w_mode_chg && ((w_mode == MODE_NORMAL) || (w_mode == MODE_FAST));
    assign w_tc       = (w_mode == MODE_FAST) ? TC_FAST : TC_NORMAL;
    assign w_load_ok  = (load_day_i != '0) && (load_day_i <= DAY_MAX) && (load_slot_i <= SLOT_MAX);
    // Only an accepted load restarts the slot period.
    assign w_clr      = w_mode_chg || (load_i && w_load_ok);
    // A step pulse on the cycle the mode changes is not honoured.
    assign w_step_adv = !w_mode_chg && (w_mode == MODE_STEP) && step_i;
    assign w_adv      = w_pre_adv || w_step_adv;

    tick_prescaler #(
        .MAX_TICKS (NORMAL_TICKS)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tc  (w_tc),
        .run (w_run),
        .clr (w_clr),
        .adv (w_pre_adv)
    );

    // Track the previous mode so a change can be seen; captured during reset too.
    always_ff @(posedge clk) begin
        r_mode <= w_mode;
    end

    // Next calendar value and pulses: load beats advance, rejected load only flags.
    always_comb begin
        w_day_nxt       = r_day;
        w_slot_nxt      = r_slot;
        w_slot_tick_nxt = 1'b0;
        w_day_tick_nxt  = 1'b0;
        w_week_wrap_nxt = 1'b0;
        w_load_err_nxt  = 1'b0;
        if (load_i) begin
            if (w_load_ok) begin
                w_day_nxt  = load_day_i;
                w_slot_nxt = load_slot_i;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (w_adv) begin
            w_slot_tick_nxt = 1'b1;
            if (r_slot < SLOT_MAX) begin
                w_slot_nxt = r_slot + 1'b1;
            end else begin
                w_slot_nxt     = '0;
                w_day_tick_nxt = 1'b1;
                if (r_day < DAY_MAX) begin
                    w_day_nxt = r_day + 1'b1;
                end else begin
                    w_day_nxt       = DAY_FIRST;
                    w_week_wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Calendar and pulse registers; pulses line up with the value they announce.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_day       <= DAY_FIRST;
            r_slot      <= '0;
            r_slot_tick <= 1'b0;
            r_day_tick  <= 1'b0;
            r_week_wrap <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_day       <= w_day_nxt;
            r_slot      <= w_slot_nxt;
            r_slot_tick <= w_slot_tick_nxt;
            r_day_tick  <= w_day_tick_nxt;
            r_week_wrap <= w_week_wrap_nxt;
            r_load_err  <= w_load_err_nxt;
        end
    end

    assign day_o       = r_day;
    assign slot_o      = r_slot;
    assign r_time_o    = {r_day, r_slot};
    assign slot_tick_o = r_slot_tick;
    assign day_tick_o  = r_day_tick;
    assign week_wrap_o = r_week_wrap;
    assign load_err_o  = r_load_err;

endmodule

// File: tb/tb_cinema_time_gen.sv
// Directed bench for cinema_time_gen: expected events are queued with the cycle
// they must appear on; a negedge monitor pops and compares them, and requires
// all pulses low on every other cycle.
module tb_cinema_time_gen;
    import cinema_pkg::*;

    localparam int NT = 10;
    localparam int FT = 2;
    localparam int ND = 3;
    localparam int NS = 4;
    localparam int DW = 5;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_i;
    logic          step_i;
    logic          load_i;
    logic [DW-1:0] load_day_i;
    logic [SW-1:0] load_slot_i;
    logic [DW-1:0] day_o;
    logic [SW-1:0] slot_o;
    logic [DW+SW-1:0] r_time_o;
    logic          slot_tick_o;
    logic          day_tick_o;
    logic          week_wrap_o;
    logic          load_err_o;

    cinema_time_gen #(
        .NORMAL_TICKS (NT),
        .FAST_TICKS   (FT),
        .DAYS         (ND),
        .SLOTS        (NS),
        .DAY_W        (DW),
        .SLOT_W       (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode_i),
        .step_i      (step_i),
        .load_i      (load_i),
        .load_day_i  (load_day_i),
        .load_slot_i (load_slot_i),
        .day_o       (day_o),
        .slot_o      (slot_o),
        .r_time_o    (r_time_o),
        .slot_tick_o (slot_tick_o),
        .day_tick_o  (day_tick_o),
        .week_wrap_o (week_wrap_o),
        .load_err_o  (load_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector order: {slot_tick, day_tick, week_wrap, load_err}.
    typedef struct {
        int         cyc;
        int         day;
        int         slot;
        logic [3:0] pl;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic void exp_ev(input int c, input int d, input int s, input logic [3:0] p);
        ev_t e;
        e.cyc  = c;
        e.day  = d;
        e.slot = s;
        e.pl   = p;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        ev_t        e;
        logic [3:0] pl;
        if (mon_en) begin
            pl = {slot_tick_o, day_tick_o, week_wrap_o, load_err_o};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $error("FAIL missed_event cycle %0d: observed none expected event at %0d (%0d,%0d)",
                       cyc, sb[0].cyc, sb[0].day, sb[0].slot);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("day", 32'(day_o), 32'(e.day));
                chk("slot", 32'(slot_o), 32'(e.slot));
                chk("time", 32'(r_time_o), 32'((e.day << SW) | e.slot));
                chk("pulses", 32'(pl), 32'(e.pl));
            end else begin
                chk("idle_pulses", 32'(pl), 32'h0);
            end
        end
    end

    task automatic clk_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) clk_step(1);
    endtask

    // Hold rst for n edges with mode m; base is the last edge that sampled rst.
    task automatic do_reset(input logic [1:0] m, input int n, output int base);
        rst    = 1'b1;
        mode_i = m;
        step_i = 1'b0;
        load_i = 1'b0;
        clk_step(n);
        base = cyc;
        rst  = 1'b0;
        exp_ev(base, 1, 0, 4'b0000);
    endtask

    task automatic load_at(input int c, input int d, input int s);
        wait_until(c);
        load_day_i  = DW'(d);
        load_slot_i = SW'(s);
        load_i      = 1'b1;
        clk_step(1);
        load_i      = 1'b0;
    endtask

    initial begin
        int         b;
        int         g;
        logic [3:0] p;
        rst         = 1'b1;
        mode_i      = MODE_NORMAL;
        step_i      = 1'b0;
        load_i      = 1'b0;
        load_day_i  = '0;
        load_slot_i = '0;

        // 1: normal mode, one advance every NT cycles, day and week wraps.
        do_reset(MODE_NORMAL, 2, b);
        mon_en = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            p = {1'b1, (i % NS) == 0, (i % (NS * ND)) == 0, 1'b0};
            exp_ev(b + NT * i, 1 + (i / NS) % ND, i % NS, p);
        end
        wait_until(b + 130);

        // 2: fast mode, then switch to normal while the prescaler sits at 1.
        do_reset(MODE_FAST, 2, b);
        exp_ev(b + 2, 1, 1, 4'b1000);
        exp_ev(b + 4, 1, 2, 4'b1000);
        exp_ev(b + 6, 1, 3, 4'b1000);
        wait_until(b + 7);
        mode_i = MODE_NORMAL;
        exp_ev(b + 18, 2, 0, 4'b1100);
        exp_ev(b + 28, 2, 1, 4'b1000);
        wait_until(b + 30);

        // 3: step mode, five spaced steps; then steps in pause are ignored.
        do_reset(MODE_STEP, 2, b);
        for (int i = 0; i < 5; i++) begin
            wait_until(b + 2 + 3 * i);
            step_i = 1'b1;
            p = {1'b1, ((i + 1) % NS) == 0, 2'b00};
            exp_ev(b + 3 + 3 * i, 1 + (i + 1) / NS, (i + 1) % NS, p);
            clk_step(1);
            step_i = 1'b0;
        end
        wait_until(b + 16);
        mode_i = MODE_PAUSE;
        for (int i = 0; i < 2; i++) begin
            wait_until(b + 18 + 3 * i);
            step_i = 1'b1;
            clk_step(1);
            step_i = 1'b0;
        end
        exp_ev(b + 24, 2, 1, 4'b0000);

        // 4: load (3,3), step to week wrap, then out-of-range loads rejected.
        exp_ev(b + 26, 3, 3, 4'b0000);
        load_at(b + 25, 3, 3);
        wait_until(b + 27);
        mode_i = MODE_STEP;
        wait_until(b + 29);
        exp_ev(b + 30, 1, 0, 4'b1110);
        step_i = 1'b1;
        clk_step(1);
        step_i = 1'b0;
        exp_ev(b + 33, 1, 0, 4'b0001);
        exp_ev(b + 36, 1, 0, 4'b0001);
        exp_ev(b + 39, 1, 0, 4'b0001);
        exp_ev(b + 41, 1, 0, 4'b0000);
        load_at(b + 32, 0, 1);
        load_at(b + 35, 2, NS);
        load_at(b + 38, ND + 1, 0);
        wait_until(b + 42);

        // 5: load coincides with a fast-mode advance; the load wins.
        do_reset(MODE_FAST, 2, b);
        exp_ev(b + 2, 2, 2, 4'b0000);
        exp_ev(b + 4, 2, 3, 4'b1000);
        exp_ev(b + 6, 3, 0, 4'b1100);
        load_at(b + 1, 2, 2);
        wait_until(b + 7);

        // 6: reset mid-run at (2,2) with the prescaler at 7.
        do_reset(MODE_NORMAL, 2, b);
        for (int i = 1; i <= 6; i++) begin
            p = {1'b1, (i % NS) == 0, 2'b00};
            exp_ev(b + NT * i, 1 + (i / NS) % ND, i % NS, p);
        end
        wait_until(b + 67);
        do_reset(MODE_NORMAL, 1, g);
        exp_ev(g + NT, 1, 1, 4'b1000);
        wait_until(g + NT + 3);

        chk("queue_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cinema_time_gen.md
Name: cinema_time_gen

Overview:
- Parametrised successor to the cinema show-time base. Generates the simulated (day, slot) calendar that drives scheduling and display logic.
- Single clock domain: a prescaler produces a one-cycle advance enable. No derived clocks.
- Adds programmable calendar size, four run modes (normal / fast / pause / single-step), time load, and event pulses for downstream schedulers.

Parameters:
- NORMAL_TICKS, 1_000_000_000: clk cycles per slot advance in normal mode (10 s at 100 MHz).
- FAST_TICKS, 50_000_000: clk cycles per slot advance in fast mode; must be >=1 and <= NORMAL_TICKS.
- DAYS, 7: days per week; day numbering is 1..DAYS.
- SLOTS, 10: slots per day; slot numbering is 0..SLOTS-1.
- DAY_W, 5: width of the day field; must satisfy 2**DAY_W > DAYS.
- SLOT_W, 5: width of the slot field; must satisfy 2**SLOT_W >= SLOTS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode_i  in  2  run mode: 00 normal, 01 fast, 10 pause, 11 step
- step_i  in  1  single-cycle pulse; advances one slot, honoured only in step mode
- load_i  in  1  single-cycle pulse; loads load_day_i / load_slot_i
- load_day_i  in  DAY_W  day value to load
- load_slot_i  in  SLOT_W  slot value to load
- day_o  out  DAY_W  current day
- slot_o  out  SLOT_W  current slot
- r_time_o  out  DAY_W+SLOT_W  {day_o, slot_o}
- slot_tick_o  out  1  one-cycle pulse on every slot advance
- day_tick_o  out  1  one-cycle pulse when slot wraps to 0
- week_wrap_o  out  1  one-cycle pulse when day wraps DAYS->1
- load_err_o  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst=1 at a clk edge): day_o=1, slot_o=0, prescaler=0, all pulse outputs 0. The reset overrides every other input.
- Prescaler:
  - Terminal count TC = NORMAL_TICKS-1 in mode 00, FAST_TICKS-1 in mode 01.
  - Counts 0..TC. On the cycle it reaches TC it raises the advance enable (adv) and returns to 0.
  - Holds at 0 in modes 10 and 11.
- Mode change: any change of mode_i versus its registered value clears the prescaler to 0 in that cycle, with no adv. The counter therefore never sits above a new, smaller TC.
- Step mode: adv = step_i. A step_i pulse in any other mode is ignored.
- Advance (adv=1, no load in that cycle):
  - If slot < SLOTS-1: slot increments.
  - Else slot -> 0, day_tick_o=1, and the day advances: day < DAYS increments; day == DAYS goes to 1 with week_wrap_o=1.
- Pulse timing: slot_tick_o, day_tick_o and week_wrap_o are registered. They assert in the same cycle the new day/slot value first appears on the outputs.
- Load:
  - Accepted when 1 <= load_day_i <= DAYS and load_slot_i < SLOTS. An accepted load updates day/slot on the next edge and clears the prescaler. It produces no tick pulses.
  - Out-of-range values are rejected: state is unchanged and load_err_o pulses for one cycle.
- Priority: rst > load_i > adv. When a load coincides with adv, the load wins and that adv is dropped.
- Latency:
  - In mode 00/01, the first advance after reset or a mode entry occurs TC+1 cycles later.
  - In step mode, day/slot update on the edge after step_i is sampled (1-cycle latency).
- Pause: day/slot hold indefinitely and all pulses stay 0. Resuming restarts the prescaler from 0.
- Width rule: all comparisons use the declared field widths; no arithmetic wraps beyond DAYS/SLOTS.
- Outputs are fully registered, with no combinational path from inputs to outputs.

Decomposition:
- cinema_pkg holds:
  - the mode encodings (MODE_NORMAL, MODE_FAST, MODE_PAUSE, MODE_STEP);
  - the default constants DAYS_DEF=7, SLOTS_DEF=10, DAY_W_DEF=5, SLOT_W_DEF=5.
- Sub-module tick_prescaler:
  - Parameter: MAX_TICKS.
  - Inputs: tc (runtime terminal count), run, clr.
  - Output: adv.
  - Counter width is $clog2(MAX_TICKS).
- The calendar counter, load check and pulse generation stay in cinema_time_gen.

Test Plan:
All scenarios use NORMAL_TICKS=10, FAST_TICKS=2, DAYS=3, SLOTS=4.
1. Reset, mode 00, run 130 cycles -> slot advances every 10 cycles. After 40 cycles day=2, slot=0, with day_tick_o pulsing in that cycle. After 120 cycles day=1, slot=0, with week_wrap_o pulsing once.
2. Mode 01 from reset -> slot_tick_o every 2 cycles. Switch to 00 when the prescaler is at 1 -> no advance on the switch cycle; the next advance comes exactly 10 cycles later.
3. Mode 11: issue 5 step_i pulses spaced 3 cycles apart -> (1,0)->(1,1)->(1,2)->(1,3)->(2,0)->(2,1). step_i pulses issued in mode 10 leave the state unchanged.
4. Load (3,3), then a step -> day=1, slot=0, with day_tick_o and week_wrap_o both pulsing. Load (0,1) and (2,4) -> each is rejected with a load_err_o pulse and the state is unchanged.
5. load_i coincident with adv in mode 01 -> the loaded value appears, slot_tick_o stays 0, and the next advance comes 2 cycles after the load.
6. Assert rst mid-run at (2,2) with the prescaler at 7 -> next cycle day=1, slot=0, pulses 0. After release, the first advance comes 10 cycles later.
